pulse_mult: RTL and testbench

Pulse-rate multiplier: the complement of the `div` pulse divider. It measures the period between rising edges on `inp_i` and emits `MULTIPLIER` evenly spaced one-cycle pulses on `out_o` within each following input period. It uses a DDA accumulator instead of a hardware divider. It sits in the position-bus pulse processing chain next to `div`, `pulse` and `seq`, and is driven by the same register-strobe interface.

---
 rtl/pulse_mult_if.sv | 43 ++++
 rtl/pulse_mult.sv | 243 ++++++++++++++++++++++++
 tb/tb_pulse_mult.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_mult_if.sv
// -----------------------------------------------------------------------------
// pulse_mult_if
//
// Register-strobe bus between the position-bus register block and the
// pulse_mult multiplier.
//
// Signals:
//   MULTIPLIER       [MW-1:0]  pulses per input period (register value)
//   MULTIPLIER_WSTB            one-cycle write strobe for MULTIPLIER
//   PERIOD           [PW-1:0]  last measured input period, in clocks
//   COUNT            [PW-1:0]  output pulses since enable
//   STATUS           [1:0]     sticky flags: bit0 overrun, bit1 timeout
//
// Modports:
//   master : register block side (drives MULTIPLIER/WSTB, reads readbacks)
//   slave  : pulse_mult side
// -----------------------------------------------------------------------------
interface pulse_mult_if #(
    parameter int PW = 32,
    parameter int MW = 16
);
    logic [MW-1:0] MULTIPLIER;
    logic          MULTIPLIER_WSTB;
    logic [PW-1:0] PERIOD;
    logic [PW-1:0] COUNT;
    logic [1:0]    STATUS;

    modport master (
        output MULTIPLIER,
        output MULTIPLIER_WSTB,
        input  PERIOD,
        input  COUNT,
        input  STATUS
    );

    modport slave (
        input  MULTIPLIER,
        input  MULTIPLIER_WSTB,
        output PERIOD,
        output COUNT,
        output STATUS
    );
endinterface

// File: rtl/pulse_mult.sv
// -----------------------------------------------------------------------------
// pulse_mult
//
// Pulse-rate multiplier. Measures the period P between rising edges of inp_i
// and emits M = MULTIPLIER evenly spaced one-cycle pulses on out_o during the
// following input period. Pulse spacing comes from a DDA accumulator (add M
// every cycle, emit and subtract P on crossing) so no divider is needed.
//
// Ports:
//   clk_i     in   system clock, rising edge
//   reset_i   in   asynchronous active-high reset
//   inp_i     in   input pulse train, rising edges significant
//   enable_i  in   block enable, level sensitive
//   out_o     out  multiplied pulse train (registered)
//   regs      slave modport of pulse_mult_if
//                  (MULTIPLIER, MULTIPLIER_WSTB, PERIOD, COUNT, STATUS)
//
// Configuration macro:
//   PULSE_MULT_TIMEOUT_EN  when defined, a saturated period counter returns
//                          the block to MEASURE and sets STATUS[1]. When
//                          undefined the counter saturates silently and
//                          STATUS[1] stays 0.
// -----------------------------------------------------------------------------
module pulse_mult #(
    parameter int PW = 32,
    parameter int MW = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inp_i,
    input  logic         enable_i,
    output logic         out_o,
    pulse_mult_if.slave  regs
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_ARMED   = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [PW-1:0] PC_MAX = '1;
    localparam logic [PW-1:0] PC_ONE = PW'(1);

    // -------------------------------------------------------------------------
    // Registers and their next-state values
    // -------------------------------------------------------------------------
    state_t        r_state,   w_state_next;
    logic          r_inp_prev;
    logic [PW-1:0] r_pc,      w_pc_next;
    logic [PW-1:0] r_period,  w_period_next;
    logic [PW-1:0] r_count,   w_count_next;
    logic [1:0]    r_status,  w_status_next;
    logic [PW:0]   r_acc,     w_acc_next;
    logic [MW-1:0] r_m,       w_m_next;
    logic [MW-1:0] r_emitted, w_emitted_next;
    logic          r_out,     w_out_next;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic          w_edge;
    logic          w_counting;
    logic          w_timeout;
    logic          w_group_start;
    logic [PW-1:0] w_pc_inc;
    logic [PW:0]   w_acc_sum;
    logic [PW:0]   w_p_ext;

    // Enable gates the edge so nothing seen while disabled can start a group.
    assign w_edge     = inp_i & ~r_inp_prev & enable_i;
    assign w_counting = (r_state == ST_ARMED) || (r_state == ST_RUN);
    assign w_pc_inc   = (r_pc == PC_MAX) ? r_pc : (r_pc + PC_ONE);

    // One bit wider than the period so acc + M never wraps before the compare.
    assign w_acc_sum  = r_acc + (PW+1)'(r_m);
    assign w_p_ext    = {1'b0, r_period};

`ifdef PULSE_MULT_TIMEOUT_EN
    // An edge in the saturating cycle still counts as a valid period.
    assign w_timeout  = w_counting & (r_pc == PC_MAX) & ~w_edge;
`else
    assign w_timeout  = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_period_next  = r_period;
        w_count_next   = r_count;
        w_status_next  = r_status;
        w_acc_next     = r_acc;
        w_m_next       = r_m;
        w_emitted_next = r_emitted;
        w_out_next     = 1'b0;
        w_group_start  = 1'b0;

        if (!enable_i) begin
            // PERIOD, COUNT and STATUS hold; output forced low next cycle.
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Enable just rose: fresh measurement, clear readbacks.
                    w_count_next  = '0;
                    w_status_next = '0;
                    if (w_edge) begin
                        // Edge coinciding with enable rising is the first
                        // measurement edge.
                        w_state_next = ST_ARMED;
                        w_pc_next    = PC_ONE;
                    end else begin
                        w_state_next = ST_MEASURE;
                    end
                end

                ST_MEASURE: begin
                    if (w_edge) begin
                        w_state_next = ST_ARMED;
                        w_pc_next    = PC_ONE;
                    end
                end

                ST_ARMED: begin
                    if (w_edge) begin
                        w_state_next  = ST_RUN;
                        w_period_next = r_pc;
                        w_pc_next     = PC_ONE;
                        w_group_start = 1'b1;
                    end else if (w_timeout) begin
                        w_state_next     = ST_MEASURE;
                        w_status_next[1] = 1'b1;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end

                ST_RUN: begin
                    if (w_edge) begin
                        // Pulses still owed from the old group are dropped.
                        if (r_emitted < r_m) begin
                            w_status_next[0] = 1'b1;
                        end
                        w_period_next = r_pc;
                        w_pc_next     = PC_ONE;
                        w_group_start = 1'b1;
                    end else if (w_timeout) begin
                        w_state_next     = ST_MEASURE;
                        w_status_next[1] = 1'b1;
                    end else begin
                        w_pc_next = w_pc_inc;
                        if (regs.MULTIPLIER_WSTB) begin
                            // Abandon the group; the new value is picked up
                            // at the next edge.
                            w_emitted_next = r_m;
                        end else if (w_acc_sum >= w_p_ext) begin
                            if (r_emitted < r_m) begin
                                w_out_next     = 1'b1;
                                w_count_next   = r_count + PC_ONE;
                                w_emitted_next = r_emitted + MW'(1);
                                w_acc_next     = w_acc_sum - w_p_ext;
                            end else begin
                                // Group complete: park the accumulator.
                                w_acc_next = w_p_ext;
                            end
                        end else begin
                            w_acc_next = w_acc_sum;
                        end
                    end
                end

                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        // Group start overrides any DDA decision made in the same cycle, so a
        // crossing coincident with an edge collapses into the start pulse.
        if (w_group_start) begin
            w_m_next       = regs.MULTIPLIER;
            w_acc_next     = '0;
            w_emitted_next = MW'(1);
            if (regs.MULTIPLIER != '0) begin
                w_out_next   = 1'b1;
                w_count_next = r_count + PC_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_inp_prev <= 1'b0;
            r_pc       <= '0;
            r_period   <= '0;
            r_count    <= '0;
            r_status   <= '0;
            r_acc      <= '0;
            r_m        <= '0;
            r_emitted  <= '0;
            r_out      <= 1'b0;
        end else begin
            // Tracked regardless of enable so a level already high at enable
            // time is not mistaken for an edge.
            r_inp_prev <= inp_i;
            r_pc       <= w_pc_next;
            r_period   <= w_period_next;
            r_count    <= w_count_next;
            r_status   <= w_status_next;
            r_acc      <= w_acc_next;
            r_m        <= w_m_next;
            r_emitted  <= w_emitted_next;
            r_out      <= w_out_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_o       = r_out;
    assign regs.PERIOD = r_period;
    assign regs.COUNT  = r_count;
    assign regs.STATUS = r_status;

endmodule

// File: tb/tb_pulse_mult.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pulse_mult
//
// Scoreboard bench for pulse_mult. Each driven input edge pushes the pulse
// times the multiplier must produce (e+1+k_j, k_j = ceil(j*P/M), truncated at
// the next edge or enable drop) into a queue; a negedge monitor pops and
// compares them against out_o, flagging both missing and unexpected pulses.
// -----------------------------------------------------------------------------
module tb_pulse_mult;

`ifdef PULSE_MULT_TIMEOUT_EN
    localparam int PW = 8;
    localparam int MW = 8;
`else
    localparam int PW = 32;
    localparam int MW = 16;
`endif
    localparam longint CMASK = (longint'(1) << PW) - 1;

    logic clk_i = 1'b0;
    logic reset_i;
    logic inp_i;
    logic enable_i;
    logic out_o;

    pulse_mult_if #(.PW(PW), .MW(MW)) regs ();

    pulse_mult #(.PW(PW), .MW(MW)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .inp_i    (inp_i),
        .enable_i (enable_i),
        .out_o    (out_o),
        .regs     (regs)
    );

    always #5 clk_i = ~clk_i;

    longint cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    longint exp_q[$];
    longint exp_count = 0;
    int     n_checks  = 0;
    int     n_fail    = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set_mult(input int m);
        regs.MULTIPLIER      = MW'(m);
        regs.MULTIPLIER_WSTB = 1'b1;
        tick(1);
        regs.MULTIPLIER_WSTB = 1'b0;
    endtask

    // Expected pulses of one group: edge sampled in cycle e, period p,
    // multiplier m, output cut off g cycles after the edge.
    task automatic expect_group(input longint e, input int p, input int m,
                                input int g, output int n);
        longint k;
        n = 0;
        for (int j = 0; j < m; j++) begin
            k = (longint'(j) * p + m - 1) / m;
            if (k < g) begin
                exp_q.push_back(e + 1 + k);
                exp_count++;
                n++;
            end
        end
    endtask

    // Drive one rising edge now; p = 0 means an arming edge (no group).
    // Returns g cycles later, i.e. at the next edge time.
    task automatic drive_edge(input int m, input int p, input int g, input bit wstb);
        longint e;
        int     n;
        e = cyc;
        n = 0;
        if (p > 0) expect_group(e, p, m, g, n);
        if (wstb) begin
            regs.MULTIPLIER      = MW'(m);
            regs.MULTIPLIER_WSTB = 1'b1;
        end
        inp_i = 1'b1;
        tick(1);
        inp_i = 1'b0;
        regs.MULTIPLIER_WSTB = 1'b0;
        if (p > 0) check("period", longint'(regs.PERIOD), longint'(p));
        tick(g - 1);
        check("count", longint'(regs.COUNT), exp_count & CMASK);
        $display("edge @%0d P=%0d M=%0d gap=%0d wstb=%0d pulses=%0d",
                 e, p, m, g, wstb, n);
    endtask

    // Pulse monitor
    always @(negedge clk_i) begin
        bit want;
        want = 1'b0;
        if (!reset_i) begin
            if (exp_q.size() > 0) begin
                if (exp_q[0] == cyc) begin
                    want = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
            if (out_o || want)
                check($sformatf("out_o@%0d", cyc), longint'(out_o), longint'(want));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i              = 1'b1;
        inp_i                = 1'b0;
        enable_i             = 1'b0;
        regs.MULTIPLIER      = '0;
        regs.MULTIPLIER_WSTB = 1'b0;
        tick(3);
        check("rst_out",    longint'(out_o),       0);
        check("rst_period", longint'(regs.PERIOD), 0);
        check("rst_count",  longint'(regs.COUNT),  0);
        check("rst_status", longint'(regs.STATUS), 0);
        reset_i = 1'b0;
        tick(2);

        // Start-up (edge coincident with enable rise) and basic M=4
        set_mult(4);
        enable_i  = 1'b1;
        exp_count = 0;
        drive_edge(4, 0, 50, 1'b0);
        drive_edge(4, 50, 100, 1'b0);
        repeat (3) drive_edge(4, 100, 100, 1'b0);
        drive_edge(4, 100, 60, 1'b0);           // enable drops mid-group
        enable_i = 1'b0;
        tick(20);
        check("hold_period", longint'(regs.PERIOD), 100);
        check("hold_count",  longint'(regs.COUNT),  exp_count & CMASK);

        // Overrun: M=8, P=80, then an edge 40 cycles later
        set_mult(8);
        enable_i  = 1'b1;
        exp_count = 0;
        tick(1);
        check("en_clr_count", longint'(regs.COUNT), 0);
        drive_edge(8, 0, 80, 1'b0);
        drive_edge(8, 80, 80, 1'b0);
        check("pre_ovr_status", longint'(regs.STATUS), 0);
        drive_edge(8, 80, 40, 1'b0);
        check("pre_ovr_status2", longint'(regs.STATUS), 0);
        drive_edge(8, 40, 60, 1'b0);
        check("ovr_status", longint'(regs.STATUS), 1);
        enable_i = 1'b0;
        tick(5);

        // Slowdown: M=2, P=10 then a 30-cycle gap
        set_mult(2);
        enable_i  = 1'b1;
        exp_count = 0;
        tick(1);
        check("en_clr_status", longint'(regs.STATUS), 0);
        drive_edge(2, 0, 10, 1'b0);
        drive_edge(2, 10, 30, 1'b0);
        drive_edge(2, 30, 40, 1'b0);
        enable_i = 1'b0;
        tick(5);

        // Write strobe mid-group, then strobe coincident with an edge
        set_mult(5);
        enable_i  = 1'b1;
        exp_count = 0;
        tick(1);
        drive_edge(5, 0, 100, 1'b0);
        drive_edge(5, 100, 100, 1'b0);
        drive_edge(5, 100, 10, 1'b0);           // only the start pulse survives
        regs.MULTIPLIER      = MW'(3);
        regs.MULTIPLIER_WSTB = 1'b1;
        tick(1);
        regs.MULTIPLIER_WSTB = 1'b0;
        tick(89);
        drive_edge(3, 100, 100, 1'b0);
        check("wstb_no_ovr", longint'(regs.STATUS), 0);
        drive_edge(2, 100, 100, 1'b1);
        check("wstb_edge_status", longint'(regs.STATUS), 0);
        enable_i = 1'b0;
        tick(5);

        // Reset in the middle of a group
        set_mult(4);
        enable_i  = 1'b1;
        exp_count = 0;
        tick(1);
        drive_edge(4, 0, 100, 1'b0);
        drive_edge(4, 100, 26, 1'b0);           // now inside the k=25 pulse
        check("pre_rst_out", longint'(out_o), 1);
        exp_q.delete();
        exp_count = 0;
        reset_i   = 1'b1;
        #1;
        check("mid_rst_out",    longint'(out_o),       0);
        check("mid_rst_period", longint'(regs.PERIOD), 0);
        check("mid_rst_count",  longint'(regs.COUNT),  0);
        check("mid_rst_status", longint'(regs.STATUS), 0);
        enable_i = 1'b0;
        tick(3);
        reset_i = 1'b0;
        repeat (2) begin
            inp_i = 1'b1;
            tick(1);
            inp_i = 1'b0;
            tick(20);
        end
        enable_i = 1'b1;
        tick(1);
        drive_edge(4, 0, 40, 1'b0);
        drive_edge(4, 40, 40, 1'b0);
        enable_i = 1'b0;
        tick(5);

`ifdef PULSE_MULT_TIMEOUT_EN
        // Timeout: no edge for 255 cycles saturates the period counter
        enable_i  = 1'b1;
        exp_count = 0;
        tick(1);
        drive_edge(4, 0, 50, 1'b0);
        drive_edge(4, 50, 300, 1'b0);
        check("tmo_status", longint'(regs.STATUS), 2);
        check("tmo_period_hold", longint'(regs.PERIOD), 50);
        drive_edge(4, 0, 50, 1'b0);             // back in MEASURE: arming only
        check("tmo_rearm_period", longint'(regs.PERIOD), 50);
        drive_edge(4, 50, 60, 1'b0);
        enable_i = 1'b0;
        tick(5);
`endif

        tick(5);
        check("queue_drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
